range_stats: RTL and testbench

RANGE_STATS -- requirements
Module: range_stats

---
 rtl/range_stats_pkg.sv | 15 +
 rtl/range_channel.sv | 163 ++++++++++++++++
 rtl/range_stats.sv | 49 ++++
 tb/tb_range_stats.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/range_stats_pkg.sv
// Shared types and default sizing for the range_stats block.
// Holds the per-channel state encoding and the default parameter values.
package range_stats_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/range_channel.sv
// One independent range/min/max/count tracker with its own IDLE/RUN/ERR FSM.
// Results are registered on an accepted finish and held until the next one.
module range_channel
    import range_stats_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             go,
    input  logic             finish,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] range,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic             busy,
    output logic             error
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] high_reg, high_next;
    logic [WIDTH-1:0] low_reg, low_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic [WIDTH-1:0] range_reg, range_next;
    logic [WIDTH-1:0] min_reg, min_next;
    logic [WIDTH-1:0] max_reg, max_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             done_reg, done_next;

    logic             start;
    logic             accum;
    logic             accept;
    logic [WIDTH-1:0] sample_hi;
    logic [WIDTH-1:0] sample_lo;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic greater(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic m);
        if (m)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    assign start  = go & ~finish;
    assign accum  = (state_reg == RUN) & ~go;
    assign accept = accum & finish;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (go && finish) begin
            state_next = ERR;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (go)
                        state_next = RUN;
                    else if (finish)
                        state_next = ERR;
                end
                RUN: begin
                    if (finish)
                        state_next = IDLE;
                end
                ERR: begin
                    if (go)
                        state_next = RUN;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy  = (state_reg == RUN);
        error = (state_reg == ERR);
    end

    always_comb begin
        sample_hi  = greater(data_in, high_reg, mode_reg) ? data_in : high_reg;
        sample_lo  = greater(low_reg, data_in, mode_reg) ? data_in : low_reg;
        cnt_inc    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

        high_next  = high_reg;
        low_next   = low_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        range_next = range_reg;
        min_next   = min_reg;
        max_next   = max_reg;
        count_next = count_reg;
        done_next  = 1'b0;

        if (start) begin
            high_next = data_in;
            low_next  = data_in;
            cnt_next  = {{(CNT_W-1){1'b0}}, 1'b1};
            mode_next = signed_mode;
        end else if (accum) begin
            high_next = sample_hi;
            low_next  = sample_lo;
            cnt_next  = cnt_inc;
        end

        if (accept) begin
            // The low WIDTH bits of a modular subtraction equal the widened
            // difference truncated, so signed extremes wrap to the right value.
            range_next = sample_hi - sample_lo;
            min_next   = sample_lo;
            max_next   = sample_hi;
            count_next = cnt_inc;
            done_next  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            high_reg  <= '0;
            low_reg   <= '0;
            cnt_reg   <= '0;
            mode_reg  <= 1'b0;
            range_reg <= '0;
            min_reg   <= '0;
            max_reg   <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            high_reg  <= high_next;
            low_reg   <= low_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            range_reg <= range_next;
            min_reg   <= min_next;
            max_reg   <= max_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    assign range   = range_reg;
    assign min_val = min_reg;
    assign max_val = max_reg;
    assign count   = count_reg;
    assign done    = done_reg;

endmodule

// File: rtl/range_stats.sv
// Multi-channel range statistics: CHANNELS independent range_channel instances
// sharing only the clock and reset, with flat packed per-channel buses.
module range_stats
    import range_stats_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       go,
    input  logic [CHANNELS-1:0]       finish,
    input  logic [CHANNELS-1:0]       signed_mode,
    output logic [CHANNELS*WIDTH-1:0] range,
    output logic [CHANNELS*WIDTH-1:0] min_val,
    output logic [CHANNELS*WIDTH-1:0] max_val,
    output logic [CHANNELS*CNT_W-1:0] count,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       error
);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            range_channel #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_chan (
                .clock       (clock),
                .reset       (reset),
                .data_in     (data_in[gi*WIDTH +: WIDTH]),
                .go          (go[gi]),
                .finish      (finish[gi]),
                .signed_mode (signed_mode[gi]),
                .range       (range[gi*WIDTH +: WIDTH]),
                .min_val     (min_val[gi*WIDTH +: WIDTH]),
                .max_val     (max_val[gi*WIDTH +: WIDTH]),
                .count       (count[gi*CNT_W +: CNT_W]),
                .done        (done[gi]),
                .busy        (busy[gi]),
                .error       (error[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_range_stats.sv
// Directed bench for range_stats (WIDTH=16, CHANNELS=2, CNT_W=8).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_range_stats;

    logic        clock;
    logic        reset;
    logic [31:0] data_in;
    logic [1:0]  go;
    logic [1:0]  finish;
    logic [1:0]  signed_mode;
    logic [31:0] range;
    logic [31:0] min_val;
    logic [31:0] max_val;
    logic [15:0] count;
    logic [1:0]  done;
    logic [1:0]  busy;
    logic [1:0]  error;

    int checks = 0;
    int errors = 0;

    range_stats #(.WIDTH(16), .CHANNELS(2), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .go          (go),
        .finish      (finish),
        .signed_mode (signed_mode),
        .range       (range),
        .min_val     (min_val),
        .max_val     (max_val),
        .count       (count),
        .done        (done),
        .busy        (busy),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int ch, input logic g, input logic f,
                         input logic [15:0] d, input logic m);
        go[ch]              = g;
        finish[ch]          = f;
        data_in[ch*16 +: 16] = d;
        signed_mode[ch]     = m;
    endtask

    task automatic clear();
        go     = 2'b00;
        finish = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        data_in = '0; go = '0; finish = '0; signed_mode = '0;
        step();
        step();
        checks++;
        if ({range, min_val, max_val, count, done, busy, error} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs=%h required all zero",
                     {range, min_val, max_val, count, done, busy, error});
        end
        reset = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_unsigned();
        drive(0, 1, 0, 16'h7FFF, 0); step(); clear();
        checks++;
        if (busy !== 2'b01) begin
            errors++; $display("FAIL unsigned_busy: busy=%b required 01", busy);
        end
        drive(0, 0, 0, 16'h8000, 0); step();
        drive(0, 0, 0, 16'h8001, 0); step();
        drive(0, 0, 0, 16'h7FFE, 0); step();
        drive(0, 0, 1, 16'h7FFF, 0); step(); clear();
        checks++;
        if (range[15:0] !== 16'h0003 || min_val[15:0] !== 16'h7FFE ||
            max_val[15:0] !== 16'h8001 || count[7:0] !== 8'd5) begin
            errors++;
            $display("FAIL unsigned_result: range=%h min=%h max=%h count=%h required 0003 7ffe 8001 05",
                     range[15:0], min_val[15:0], max_val[15:0], count[7:0]);
        end
        checks++;
        if (done !== 2'b01 || busy !== 2'b00) begin
            errors++; $display("FAIL unsigned_done: done=%b busy=%b required 01 00", done, busy);
        end
        step();
        checks++;
        if (done !== 2'b00 || range[15:0] !== 16'h0003) begin
            errors++; $display("FAIL unsigned_done_pulse: done=%b range=%h required 00 0003", done, range[15:0]);
        end
        $display("test_unsigned: range=%h min=%h max=%h count=%0d", range[15:0], min_val[15:0], max_val[15:0], count[7:0]);
    endtask

    task automatic test_signed();
        drive(0, 1, 0, 16'h7FFF, 1); step(); clear();
        checks++;
        if (range[15:0] !== 16'h0003 || count[7:0] !== 8'd5) begin
            errors++; $display("FAIL go_holds_results: range=%h count=%h required 0003 05", range[15:0], count[7:0]);
        end
        drive(0, 0, 0, 16'h8000, 0); step();
        drive(0, 0, 1, 16'h0000, 0); step(); clear();
        checks++;
        if (range[15:0] !== 16'hFFFF || min_val[15:0] !== 16'h8000 ||
            max_val[15:0] !== 16'h7FFF || count[7:0] !== 8'd3 || done !== 2'b01) begin
            errors++;
            $display("FAIL signed_result: range=%h min=%h max=%h count=%h done=%b required ffff 8000 7fff 03 01",
                     range[15:0], min_val[15:0], max_val[15:0], count[7:0], done);
        end
        step();
        $display("test_signed: range=%h min=%h max=%h", range[15:0], min_val[15:0], max_val[15:0]);
    endtask

    task automatic test_go_finish_error();
        drive(1, 1, 1, 16'h5555, 0); step(); clear();
        checks++;
        if (error !== 2'b10 || done !== 2'b00) begin
            errors++; $display("FAIL gofinish_error: error=%b done=%b required 10 00", error, done);
        end
        checks++;
        if (range !== 32'h0000_FFFF || min_val !== 32'h0000_8000 ||
            max_val !== 32'h0000_7FFF || count !== 16'h0003) begin
            errors++;
            $display("FAIL gofinish_outputs: range=%h min=%h max=%h count=%h required 0000ffff 00008000 00007fff 0003",
                     range, min_val, max_val, count);
        end
        drive(1, 1, 0, 16'h0000, 0); step(); clear();
        checks++;
        if (error !== 2'b00 || busy !== 2'b10) begin
            errors++; $display("FAIL ch1_recover: error=%b busy=%b required 00 10", error, busy);
        end
        $display("test_go_finish_error: error=%b busy=%b", error, busy);
    endtask

    task automatic test_err_recovery();
        drive(0, 0, 1, 16'h0000, 0); step(); clear();
        checks++;
        if (error[0] !== 1'b1 || done[0] !== 1'b0) begin
            errors++; $display("FAIL finish_no_go: error0=%b done0=%b required 1 0", error[0], done[0]);
        end
        drive(0, 0, 1, 16'h0000, 0); step(); clear();
        step();
        checks++;
        if (error[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL err_persist: error0=%b busy0=%b required 1 0", error[0], busy[0]);
        end
        drive(0, 1, 0, 16'h0100, 0); step(); clear();
        checks++;
        if (error[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL err_exit: error0=%b busy0=%b required 0 1", error[0], busy[0]);
        end
        drive(0, 0, 0, 16'h0000, 0); step();
        drive(0, 0, 1, 16'hFFFF, 0); step(); clear();
        checks++;
        if (range[15:0] !== 16'hFFFF || min_val[15:0] !== 16'h0000 ||
            max_val[15:0] !== 16'hFFFF || count[7:0] !== 8'd3 ||
            done[0] !== 1'b1 || error[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_recovery_result: range=%h min=%h max=%h count=%h done0=%b error0=%b required ffff 0000 ffff 03 1 0",
                     range[15:0], min_val[15:0], max_val[15:0], count[7:0], done[0], error[0]);
        end
        step();
        $display("test_err_recovery: range=%h count=%0d", range[15:0], count[7:0]);
    endtask

    task automatic test_saturation();
        drive(0, 1, 0, 16'h1234, 0); step(); clear();
        for (int i = 0; i < 298; i++) begin
            drive(0, 0, 0, 16'h1234, 0); step();
        end
        drive(0, 0, 1, 16'h1234, 0); step(); clear();
        checks++;
        if (count[7:0] !== 8'hFF || range[15:0] !== 16'h0000 ||
            min_val[15:0] !== 16'h1234 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL saturation: count=%h range=%h min=%h done0=%b required ff 0000 1234 1",
                     count[7:0], range[15:0], min_val[15:0], done[0]);
        end
        step();
        $display("test_saturation: count=%h range=%h", count[7:0], range[15:0]);
    endtask

    task automatic test_reset_mid_run();
        drive(0, 1, 0, 16'h0005, 0); step(); clear();
        drive(0, 0, 0, 16'h0009, 0); step();
        reset = 1'b0;
        #1;
        checks++;
        if ({range, min_val, max_val, count, done, busy, error} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h required all zero",
                     {range, min_val, max_val, count, done, busy, error});
        end
        drive(0, 0, 1, 16'h0009, 0);
        step();
        clear();
        reset = 1'b1;
        step();
        checks++;
        if (done !== 2'b00 || busy !== 2'b00 || count !== 16'h0000) begin
            errors++; $display("FAIL reset_no_done: done=%b busy=%b count=%h required 00 00 0000", done, busy, count);
        end
        drive(0, 1, 0, 16'h0010, 0); step(); clear();
        checks++;
        if (busy[0] !== 1'b1 || error[0] !== 1'b0) begin
            errors++; $display("FAIL post_reset_go: busy0=%b error0=%b required 1 0", busy[0], error[0]);
        end
        drive(0, 0, 0, 16'h0030, 0); step();
        drive(0, 0, 1, 16'h0020, 0); step(); clear();
        checks++;
        if (range[15:0] !== 16'h0020 || min_val[15:0] !== 16'h0010 ||
            max_val[15:0] !== 16'h0030 || count[7:0] !== 8'd3 || done !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_result: range=%h min=%h max=%h count=%h done=%b required 0020 0010 0030 03 01",
                     range[15:0], min_val[15:0], max_val[15:0], count[7:0], done);
        end
        $display("test_reset_mid_run: range=%h count=%0d", range[15:0], count[7:0]);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_go_finish_error();
        test_err_recovery();
        test_saturation();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
